// File: rtl/pow_accum_pkg.sv
// Shared constants, the window-sum width helper and the result payload type
// for the pow_accum block.
package pow_accum_pkg;

  localparam int DATA_W_DEF     = 32;
  localparam int WINDOW_DEF     = 8;
  localparam int FIFO_DEPTH_DEF = 4;

  // A window of WINDOW unsigned samples needs log2(WINDOW) extra bits.
  function automatic int sum_width(input int data_w, input int window);
    return data_w + $clog2(window);
  endfunction

  localparam int RES_SUM_W = sum_width(DATA_W_DEF, WINDOW_DEF);
  localparam int RES_MAX_W = DATA_W_DEF;

  typedef struct packed {
    logic [RES_SUM_W-1:0] sum;
    logic [RES_MAX_W-1:0] max;
  } result_t;

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_LAST = 1'b1
  } acc_state_e;

endpackage

// File: rtl/pow_accum_if.sv
// Sample input, clear, result handshake and status of pow_accum.
// slave is the accumulator's view; master is the producer/consumer side.
interface pow_accum_if #(
  parameter int DATA_W     = pow_accum_pkg::DATA_W_DEF,
  parameter int WINDOW     = pow_accum_pkg::WINDOW_DEF,
  parameter int FIFO_DEPTH = pow_accum_pkg::FIFO_DEPTH_DEF
);
  localparam int SUM_W = pow_accum_pkg::sum_width(DATA_W, WINDOW);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic              in_vld;
  logic [DATA_W-1:0] in_data;
  logic              clr;
  logic              out_vld;
  logic              out_rdy;
  logic [SUM_W-1:0]  out_sum;
  logic [DATA_W-1:0] out_max;
  logic [CNT_W-1:0]  fifo_cnt;
  logic              overflow;

  modport slave (
    input  in_vld, in_data, clr, out_rdy,
    output out_vld, out_sum, out_max, fifo_cnt, overflow
  );

  modport master (
    output in_vld, in_data, clr, out_rdy,
    input  out_vld, out_sum, out_max, fifo_cnt, overflow
  );
endinterface

// File: rtl/pow_accum_sync_fifo.sv
// Generic single-clock FIFO; dout shows the head combinationally, one-cycle push-to-visible.
// A push while full is accepted only if a pop frees the slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (PTR_W+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_ptr_q];
  assign count   = cnt_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap by natural overflow.
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= din;
  end
endmodule

// File: rtl/pow_accum.sv
// Windowed sum/max of the pow result stream; a result is visible one cycle after its last sample.
// Input has no backpressure: a window finishing into a full, non-popping FIFO is dropped and flagged.
module pow_accum
  import pow_accum_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int WINDOW     = WINDOW_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input logic        clk,
  input logic        rst,
  pow_accum_if.slave bus
);
  localparam int SUM_W = sum_width(DATA_W, WINDOW);
  localparam int CNT_W = $clog2(WINDOW);

  acc_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SUM_W-1:0]  sum_q, sum_d, sum_next;
  logic [DATA_W-1:0] max_q, max_d, max_next;
  logic              overflow_q, overflow_d;
  logic              push, pop, fifo_full, fifo_empty;
  result_t           push_dat, head_dat;

  assign sum_next = sum_q + SUM_W'(bus.in_data);
  assign max_next = (bus.in_data > max_q) ? bus.in_data : max_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    max_d    = max_q;
    push     = 1'b0;
    push_dat = '{sum: sum_next, max: max_next};
    if (bus.clr) begin
      state_d = ST_ACC;
      cnt_d   = '0;
      sum_d   = '0;
      max_d   = '0;
    end else if (bus.in_vld) begin
      case (state_q)
        ST_ACC: begin
          sum_d = sum_next;
          max_d = max_next;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WINDOW - 2)) state_d = ST_LAST;
        end
        ST_LAST: begin
          push    = 1'b1;
          state_d = ST_ACC;
          cnt_d   = '0;
          sum_d   = '0;
          max_d   = '0;
        end
      endcase
    end
  end

  // A pop in the clearing cycle is ignored; the flush empties the FIFO anyway.
  assign pop = bus.out_vld && bus.out_rdy && !bus.clr;

  always_comb begin
    overflow_d = overflow_q;
    if (bus.clr)                          overflow_d = 1'b0;
    else if (push && fifo_full && !pop)   overflow_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_ACC;
      cnt_q      <= '0;
      sum_q      <= '0;
      max_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sum_q      <= sum_d;
      max_q      <= max_d;
      overflow_q <= overflow_d;
    end
  end

  sync_fifo #(
    .WIDTH ($bits(result_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (bus.clr),
    .push  (push),
    .pop   (pop),
    .din   (push_dat),
    .dout  (head_dat),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (bus.fifo_cnt)
  );

  // Uninitialised storage must not leak out while empty, including during reset.
  assign bus.out_vld  = !fifo_empty;
  assign bus.out_sum  = fifo_empty ? '0 : head_dat.sum;
  assign bus.out_max  = fifo_empty ? '0 : head_dat.max;
  assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_pow_accum.sv
// Randomized and directed bench for pow_accum: a window-level reference model feeds
// an expected-result queue that an independent monitor drains on each handshake.
module tb_pow_accum;
  import pow_accum_pkg::*;

  localparam int DW    = DATA_W_DEF;
  localparam int WIN   = WINDOW_DEF;
  localparam int DEPTH = FIFO_DEPTH_DEF;

  typedef struct {
    longint unsigned sum;
    longint unsigned max;
  } res_s;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pow_accum_if bus ();
  pow_accum dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int              n_checks = 0;
  int              n_errors = 0;
  int              n_pop    = 0;
  longint unsigned last_sum = 0;
  longint unsigned last_max = 0;

  res_s            exp_q[$];
  res_s            mdl_fifo[$];
  longint unsigned win_q[$];
  bit              ovf_m   = 1'b0;
  int              cur_cnt = 0;
  bit              cur_ovf = 1'b0;

  bit              hold_prev = 1'b0;
  longint unsigned prev_sum, prev_max;
  res_s            mon_r;

  function automatic void check(string name, longint unsigned got, longint unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endfunction

  // Predicts the effect of the coming rising edge from the applied inputs.
  task automatic model(input bit vld, input longint unsigned data, input bit c, input bit rdy);
    bit   full_now, pop_now;
    res_s r;
    cur_cnt = mdl_fifo.size();
    cur_ovf = ovf_m;
    if (c) begin
      win_q.delete();
      mdl_fifo.delete();
      exp_q.delete();
      ovf_m = 1'b0;
    end else begin
      full_now = (mdl_fifo.size() == DEPTH);
      pop_now  = rdy && (mdl_fifo.size() > 0);
      if (pop_now) void'(mdl_fifo.pop_front());
      if (vld) begin
        win_q.push_back(data);
        if (win_q.size() == WIN) begin
          r.sum = 0;
          r.max = 0;
          foreach (win_q[i]) begin
            r.sum += win_q[i];
            if (win_q[i] > r.max) r.max = win_q[i];
          end
          win_q.delete();
          if (!full_now || pop_now) begin
            mdl_fifo.push_back(r);
            exp_q.push_back(r);
          end else begin
            ovf_m = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic step(input bit vld, input logic [DW-1:0] data, input bit c, input bit rdy);
    @(posedge clk);
    #2;
    bus.in_vld  = vld;
    bus.in_data = data;
    bus.clr     = c;
    bus.out_rdy = rdy;
    model(vld, longint'(data), c, rdy);
  endtask

  task automatic idle(input bit rdy, input int n);
    for (int k = 0; k < n; k++) step(1'b0, DW'($urandom), 1'b0, rdy);
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic model_reset();
    win_q.delete();
    mdl_fifo.delete();
    exp_q.delete();
    ovf_m   = 1'b0;
    cur_cnt = 0;
    cur_ovf = 1'b0;
    bus.in_vld  = 1'b0;
    bus.clr     = 1'b0;
    bus.out_rdy = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("fifo_cnt", longint'(bus.fifo_cnt), longint'(cur_cnt));
      check("overflow", longint'(bus.overflow), longint'(cur_ovf));
      check("out_vld", longint'(bus.out_vld), longint'(cur_cnt != 0));
      if (hold_prev && bus.out_vld) begin
        check("hold_sum", longint'(bus.out_sum), prev_sum);
        check("hold_max", longint'(bus.out_max), prev_max);
      end
      if (bus.out_vld && bus.out_rdy && !bus.clr) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_result: got sum 0x%0h with no result expected", bus.out_sum);
        end else begin
          mon_r = exp_q.pop_front();
          check("res_sum", longint'(bus.out_sum), mon_r.sum);
          check("res_max", longint'(bus.out_max), mon_r.max);
        end
        n_pop++;
        last_sum = longint'(bus.out_sum);
        last_max = longint'(bus.out_max);
      end
      hold_prev = bus.out_vld && !bus.out_rdy && !bus.clr;
      prev_sum  = longint'(bus.out_sum);
      prev_max  = longint'(bus.out_max);
    end else begin
      hold_prev = 1'b0;
    end
  end

  initial begin
    int p0;
    bus.in_vld  = 1'b0;
    bus.in_data = '0;
    bus.clr     = 1'b0;
    bus.out_rdy = 1'b0;

    #1;
    check("rst_out_vld", longint'(bus.out_vld), 0);
    check("rst_fifo_cnt", longint'(bus.fifo_cnt), 0);
    check("rst_overflow", longint'(bus.overflow), 0);
    check("rst_out_sum", longint'(bus.out_sum), 0);
    check("rst_out_max", longint'(bus.out_max), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // 1..8 back to back
    p0 = n_pop;
    for (int i = 1; i <= 8; i++) step(1'b1, DW'(i), 1'b0, 1'b1);
    idle(1'b1, 3);
    settle();
    check("t1_count", longint'(n_pop - p0), 1);
    check("t1_sum", last_sum, 36);
    check("t1_max", last_max, 8);
    check("t1_overflow", longint'(bus.overflow), 0);

    // squares with random gaps
    p0 = n_pop;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, DW'(i * i), 1'b0, 1'b1);
      idle(1'b1, int'($urandom_range(0, 3)));
    end
    idle(1'b1, 3);
    settle();
    check("t2_count", longint'(n_pop - p0), 1);
    check("t2_sum", last_sum, 140);
    check("t2_max", last_max, 49);

    // five windows into a stalled FIFO
    for (int i = 0; i < 5 * WIN; i++) step(1'b1, DW'(25), 1'b0, 1'b0);
    idle(1'b0, 1);
    settle();
    check("t3_fifo_cnt", longint'(bus.fifo_cnt), DEPTH);
    check("t3_overflow", longint'(bus.overflow), 1);
    p0 = n_pop;
    idle(1'b1, 8);
    settle();
    check("t3_count", longint'(n_pop - p0), DEPTH);
    check("t3_sum", last_sum, 200);
    check("t3_max", last_max, 25);

    // full FIFO, window completes on a pop cycle
    step(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH * WIN + WIN - 1; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
    step(1'b1, DW'($urandom), 1'b0, 1'b1);
    idle(1'b0, 1);
    settle();
    check("t4_fifo_cnt", longint'(bus.fifo_cnt), DEPTH);
    check("t4_overflow", longint'(bus.overflow), 0);
    p0 = n_pop;
    idle(1'b1, 8);
    settle();
    check("t4_count", longint'(n_pop - p0), DEPTH);

    // clear mid-window discards the sample presented with it
    p0 = n_pop;
    for (int i = 0; i < 3; i++) step(1'b1, DW'($urandom), 1'b0, 1'b1);
    step(1'b1, DW'($urandom), 1'b1, 1'b1);
    for (int i = 1; i <= 8; i++) step(1'b1, DW'(i), 1'b0, 1'b1);
    idle(1'b1, 3);
    settle();
    check("t5_count", longint'(n_pop - p0), 1);
    check("t5_sum", last_sum, 36);
    check("t5_max", last_max, 8);
    check("t5_overflow", longint'(bus.overflow), 0);

    // asynchronous reset mid-window and mid-cycle
    for (int i = 1; i <= 8; i++) step(1'b1, DW'(i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
    idle(1'b0, 1);
    @(posedge clk);
    #3;
    check("t6_pre_out_vld", longint'(bus.out_vld), 1);
    rst = 1'b1;
    model_reset();
    #1;
    check("t6_out_vld", longint'(bus.out_vld), 0);
    check("t6_fifo_cnt", longint'(bus.fifo_cnt), 0);
    check("t6_out_sum", longint'(bus.out_sum), 0);
    check("t6_out_max", longint'(bus.out_max), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    p0 = n_pop;
    for (int i = 0; i < 8; i++) step(1'b1, DW'(32'hFFFF_FFFF), 1'b0, 1'b1);
    idle(1'b1, 3);
    settle();
    check("t6_count", longint'(n_pop - p0), 1);
    check("t6_sum", last_sum, 64'h7_FFFF_FFF8);
    check("t6_max", last_max, 64'hFFFF_FFFF);

    // random traffic with occasional clears
    for (int i = 0; i < 400; i++)
      step(($urandom % 4) != 0, DW'($urandom), ($urandom % 97) == 0, ($urandom % 3) != 0);
    idle(1'b1, 8);
    settle();
    check("drain_empty", longint'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
